// File: rtl/data_mem_io.sv
// Data-side memory and I/O block for a single-cycle CPU: word RAM, GPIO ports
// and a compare-match timer, decoded from the CPU byte address.
module data_mem_io #(
    parameter int RAM_WORDS = 64,
    parameter int GPIO_SYNC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        irq,
    output logic        addr_err
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [29:0] W_GPIO_OUT = 30'h100;
    localparam logic [29:0] W_GPIO_IN  = 30'h101;
    localparam logic [29:0] W_TCOUNT   = 30'h102;
    localparam logic [29:0] W_TCMP     = 30'h103;
    localparam logic [29:0] W_TCTRL    = 30'h104;

    logic [31:0]   mem [RAM_WORDS];
    logic [15:0]   sync_q [GPIO_SYNC];

    logic [15:0]   gpio_out_q, gpio_out_d;
    logic [31:0]   tcount_q, tcount_d;
    logic [31:0]   tcmp_q, tcmp_d;
    logic          en_q, en_d;
    logic          match_q, match_d;
    logic          autoclr_q, autoclr_d;
    logic          addr_err_q, addr_err_d;

    logic [AW-1:0] ram_idx;
    logic          ram_hit, sel_gpo, sel_gpi, sel_tcnt, sel_tcmp, sel_tctrl;
    logic          mapped, misaligned, hit_cmp;

    // Decode ignores addr[1:0]; misalignment is only reported, not blocking.
    assign ram_idx    = addr[AW+1:2];
    assign ram_hit    = (addr[31:AW+2] == '0);
    assign sel_gpo    = (addr[31:2] == W_GPIO_OUT);
    assign sel_gpi    = (addr[31:2] == W_GPIO_IN);
    assign sel_tcnt   = (addr[31:2] == W_TCOUNT);
    assign sel_tcmp   = (addr[31:2] == W_TCMP);
    assign sel_tctrl  = (addr[31:2] == W_TCTRL);
    assign mapped     = ram_hit | sel_gpo | sel_gpi | sel_tcnt | sel_tcmp | sel_tctrl;
    assign misaligned = (addr[1:0] != 2'b00);
    assign hit_cmp    = en_q && (tcount_q == tcmp_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        readdata = '0;
        if (ram_hit)        readdata = mem[ram_idx];
        else if (sel_gpo)   readdata = {16'h0000, gpio_out_q};
        else if (sel_gpi)   readdata = {16'h0000, sync_q[GPIO_SYNC-1]};
        else if (sel_tcnt)  readdata = tcount_q;
        else if (sel_tcmp)  readdata = tcmp_q;
        else if (sel_tctrl) readdata = {29'h0, autoclr_q, match_q, en_q};
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        tcmp_d     = tcmp_q;
        en_d       = en_q;
        autoclr_d  = autoclr_q;
        match_d    = match_q;
        tcount_d   = tcount_q;

        if (en_q) tcount_d = (hit_cmp && autoclr_q) ? 32'h0 : tcount_q + 32'd1;

        if (memwrite) begin
            if (sel_gpo)  gpio_out_d = writedata[15:0];
            if (sel_tcmp) tcmp_d     = writedata;
            if (sel_tcnt) tcount_d   = writedata;
            if (sel_tctrl) begin
                en_d      = writedata[0];
                autoclr_d = writedata[2];
                if (writedata[1]) match_d = 1'b0;
            end
        end

        // A match on the same edge as a W1C clear keeps MATCH set.
        if (hit_cmp) match_d = 1'b1;

        addr_err_d = memwrite && (misaligned || !mapped || sel_gpi);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            gpio_out_q <= '0;
            tcount_q   <= '0;
            tcmp_q     <= 32'hFFFF_FFFF;
            en_q       <= 1'b0;
            match_q    <= 1'b0;
            autoclr_q  <= 1'b0;
            addr_err_q <= 1'b0;
            for (int i = 0; i < GPIO_SYNC; i++) sync_q[i] <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            tcount_q   <= tcount_d;
            tcmp_q     <= tcmp_d;
            en_q       <= en_d;
            match_q    <= match_d;
            autoclr_q  <= autoclr_d;
            addr_err_q <= addr_err_d;
            sync_q[0]  <= gpio_in;
            for (int i = 1; i < GPIO_SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // NOTE: the RAM array has no reset; its contents survive reset and it maps to plain memory.
    always_ff @(posedge clk) begin
        if (memwrite && ram_hit && !reset) mem[ram_idx] <= writedata;
    end

    assign gpio_out = gpio_out_q;
    assign irq      = match_q;
    assign addr_err = addr_err_q;

endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001: Parameter RAM_WORDS, default 64, data RAM depth in 32-bit words (power of two, 16..256).
REQ-002: Parameter GPIO_SYNC, default 2, number of synchronizer flops on gpio_in (2..3).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: memwrite  input  1  CPU store strobe, one word per asserted cycle.
REQ-006: addr  input  32  CPU byte address (CPU aluResult).
REQ-007: writedata  input  32  CPU store data.
REQ-008: readdata  output  32  load data to CPU, combinational from addr.
REQ-009: gpio_in  input  16  asynchronous external input pins.
REQ-010: gpio_out  output  16  registered output pins.
REQ-011: irq  output  1  timer match interrupt, level.
REQ-012: addr_err  output  1  registered one-cycle pulse on illegal access.

Function
REQ-013: Word access only; addr[1:0] ignored for decode; addr[1:0]!=0 on a memwrite cycle SHALL set addr_err for the following cycle, and the store SHALL still occur to the word-aligned address.
REQ-014: Map: 0x000..(4*RAM_WORDS-4) RAM; 0x400 GPIO_OUT (RW, bits 15:0); 0x404 GPIO_IN (RO); 0x408 TCOUNT (RW, 32b); 0x40C TCMP (RW, 32b); 0x410 TCTRL (bit0 EN RW, bit1 MATCH W1C, bit2 AUTOCLR RW).
REQ-015: Unmapped address: read returns 0x00000000, write ignored and SHALL pulse addr_err the next cycle; write to GPIO_IN also pulses addr_err.
REQ-016: RAM write synchronous on clk when memwrite; RAM read combinational (same-cycle readdata), supporting single-cycle load.
REQ-017: Read of address written in same cycle returns old value (write visible after edge).
REQ-018: Register reads: unused bits read 0; GPIO_IN reads synchronized value, zero-extended.
REQ-019: gpio_in passes through GPIO_SYNC flops; value visible at 0x404 GPIO_SYNC cycles after change.
REQ-020: Timer: when EN=1, TCOUNT increments by 1 each cycle, wraps 0xFFFFFFFF->0.
REQ-021: When EN=1 and TCOUNT==TCMP, next edge SHALL set MATCH; if AUTOCLR=1 TCOUNT SHALL load 0 on that edge instead of incrementing.
REQ-022: CPU write to TCOUNT in the same cycle as an increment: write value wins, no increment that cycle.
REQ-023: MATCH set and W1C clear in same cycle: set wins.
REQ-024: Writing TCTRL with bit1=0 leaves MATCH unchanged; EN and AUTOCLR take written values.
REQ-025: irq = MATCH (registered state, no combinational path from inputs).

Reset
REQ-026: On reset assertion, asynchronously: gpio_out=0, TCOUNT=0, TCMP=0xFFFFFFFF, TCTRL=0, irq=0, addr_err=0, synchronizer flops=0.
REQ-027: RAM contents not reset; reset mid-count halts timer immediately and clears MATCH.
REQ-028: memwrite during reset has no effect on any register.

Verification
REQ-029: Store 0xDEADBEEF to 0x08, next cycle load 0x08 -> readdata=0xDEADBEEF; same-cycle read at the write edge returns prior value.
REQ-030: Write 0x0000A5A5 to 0x400 -> gpio_out=0xA5A5 after edge; read 0x400 -> 0x0000A5A5.
REQ-031: TCMP=3, TCTRL=0x5 (EN, AUTOCLR) -> TCOUNT 0,1,2,3,0,...; MATCH/irq=1 from edge after count 3; write 0x2 to TCTRL -> irq=0 next cycle, EN cleared.
REQ-032: gpio_in 0x0000->0x1234 -> read 0x404 returns 0x00001234 exactly 2 cycles later (GPIO_SYNC=2).
REQ-033: Store to 0x800 -> no state change, addr_err=1 for one cycle, read 0x800 -> 0; store to 0x0A -> RAM word 0x08 written, addr_err pulse.
REQ-034: Assert reset while timer running with MATCH=1 -> irq, TCOUNT, gpio_out go 0 without clock edge; RAM word 0x08 retains 0xDEADBEEF.
